// File: rtl/vga_pkg.sv
// Shared VGA 640x480@60 timing constants and widths for the timing and colour stages.
package vga_pkg;

    localparam int CNT_W    = 10;

    localparam int H_PIXELS = 800;
    localparam int H_SP     = 128;
    localparam int H_BP     = 144;
    localparam int H_FP     = 784;

    localparam int V_LINES  = 521;
    localparam int V_SP     = 2;
    localparam int V_BP     = 31;
    localparam int V_FP     = 511;

    localparam int RED_W    = 3;
    localparam int GRN_W    = 3;
    localparam int BLU_W    = 2;

endpackage

// File: rtl/vga_wrap_counter.sv
// Generic modulo-N counter with enable, synchronous active-low clear and terminal-count flag.
// count_next exposes the value the counter loads on the next edge so callers can pre-decode.
module vga_wrap_counter
    import vga_pkg::*;
#(
    parameter int N = H_PIXELS,
    parameter int W = CNT_W
) (
    input  logic         clk,
    input  logic         clr_n,
    input  logic         en,
    output logic [W-1:0] count,
    output logic [W-1:0] count_next,
    output logic         wrap
);

    localparam logic [W-1:0] LAST = W'(N - 1);
    localparam logic [W-1:0] ONE  = {{(W-1){1'b0}}, 1'b1};

    logic [W-1:0] count_r;
    logic [W-1:0] count_next_s;
    logic         wrap_s;

    assign wrap_s = (count_r == LAST);

    // next count: wrap at N-1, otherwise increment; hold when not enabled
    always_comb begin
        count_next_s = count_r;
        if (en) begin
            if (wrap_s) begin
                count_next_s = {W{1'b0}};
            end else begin
                count_next_s = count_r + ONE;
            end
        end else begin
            count_next_s = count_r;
        end
    end

    // count register with synchronous clear
    always_ff @(posedge clk) begin
        if (!clr_n) begin
            count_r <= {W{1'b0}};
        end else begin
            count_r <= count_next_s;
        end
    end

    assign count      = count_r;
    assign count_next = count_next_s;
    assign wrap       = wrap_s;

endmodule

// File: rtl/vga_640x480_timing.sv
// VGA 640x480@60 timing generator: counters, active-low syncs, vidon and frame_start.
// Define VGA_CLKDIV_EN to run from a 50 MHz clk with an internal divide-by-two pixel tick.
module vga_640x480_timing
    import vga_pkg::*;
#(
    parameter int HPIXELS = H_PIXELS,
    parameter int VLINES  = V_LINES,
    parameter int HSP     = H_SP,
    parameter int VSP     = V_SP,
    parameter int HBP     = H_BP,
    parameter int HFP     = H_FP,
    parameter int VBP     = V_BP,
    parameter int VFP     = V_FP
) (
    input  logic             clk,
    input  logic             clr_n,
    output logic             hsync,
    output logic             vsync,
    output logic [CNT_W-1:0] hc,
    output logic [CNT_W-1:0] vc,
    output logic             vidon,
    output logic             frame_start
);

    localparam logic [CNT_W-1:0] HSP_C = CNT_W'(HSP);
    localparam logic [CNT_W-1:0] VSP_C = CNT_W'(VSP);
    localparam logic [CNT_W-1:0] HBP_C = CNT_W'(HBP);
    localparam logic [CNT_W-1:0] HFP_C = CNT_W'(HFP);
    localparam logic [CNT_W-1:0] VBP_C = CNT_W'(VBP);
    localparam logic [CNT_W-1:0] VFP_C = CNT_W'(VFP);

    generate
        if (!(HPIXELS < 1024 && VLINES < 1024 &&
              HSP < HBP && HBP < HFP && HFP <= HPIXELS &&
              VSP < VBP && VBP < VFP && VFP <= VLINES)) begin : g_bad_timing
            $error("vga_640x480_timing: inconsistent timing parameters");
        end
    endgenerate

    logic             tick_s;
    logic             h_wrap_s;
    logic             v_wrap_s;
    logic             v_en_s;
    logic [CNT_W-1:0] h_next_s;
    logic [CNT_W-1:0] v_next_s;
    logic             hsync_next_s;
    logic             vsync_next_s;
    logic             vidon_next_s;
    logic             hsync_r;
    logic             vsync_r;
    logic             vidon_r;
    logic             frame_start_r;

`ifdef VGA_CLKDIV_EN
    logic phase_r;

    // divide-by-two phase; pixel tick on the second clk of each pair
    always_ff @(posedge clk) begin
        if (!clr_n) begin
            phase_r <= 1'b0;
        end else begin
            phase_r <= ~phase_r;
        end
    end

    assign tick_s = phase_r;
`else
    assign tick_s = 1'b1;
`endif

    assign v_en_s = tick_s & h_wrap_s;

    vga_wrap_counter #(.N(HPIXELS), .W(CNT_W)) u_hcnt (
        .clk        (clk),
        .clr_n      (clr_n),
        .en         (tick_s),
        .count      (hc),
        .count_next (h_next_s),
        .wrap       (h_wrap_s)
    );

    vga_wrap_counter #(.N(VLINES), .W(CNT_W)) u_vcnt (
        .clk        (clk),
        .clr_n      (clr_n),
        .en         (v_en_s),
        .count      (vc),
        .count_next (v_next_s),
        .wrap       (v_wrap_s)
    );

    // decode from next-state counts so the registered flags line up with hc/vc
    always_comb begin
        hsync_next_s = 1'b0;
        vsync_next_s = 1'b0;
        vidon_next_s = 1'b0;
        hsync_next_s = (h_next_s >= HSP_C);
        vsync_next_s = (v_next_s >= VSP_C);
        vidon_next_s = (h_next_s >= HBP_C) && (h_next_s < HFP_C) &&
                       (v_next_s >= VBP_C) && (v_next_s < VFP_C);
    end

    // output registers; frame_start marks the tick that wrapped both counters
    always_ff @(posedge clk) begin
        if (!clr_n) begin
            hsync_r       <= 1'b0;
            vsync_r       <= 1'b0;
            vidon_r       <= 1'b0;
            frame_start_r <= 1'b0;
        end else begin
            hsync_r       <= hsync_next_s;
            vsync_r       <= vsync_next_s;
            vidon_r       <= vidon_next_s;
            frame_start_r <= tick_s & h_wrap_s & v_wrap_s;
        end
    end

    assign hsync       = hsync_r;
    assign vsync       = vsync_r;
    assign vidon       = vidon_r;
    assign frame_start = frame_start_r;

endmodule

// File: tb/tb_vga_640x480_timing.sv
// Self-checking bench: full-size and scaled-down timing instances against a tick-count model.
module tb_vga_640x480_timing;

`ifdef VGA_CLKDIV_EN
    localparam int DIV = 2;
`else
    localparam int DIV = 1;
`endif

    // scaled-down geometry for the frame-level checks
    localparam int B_HP = 40, B_VL = 13, B_HSP = 4, B_HBP = 7, B_HFP = 37;
    localparam int B_VSP = 2, B_VBP = 3, B_VFP = 11;

    logic       clk = 1'b0;
    logic       clr_n;
    logic       a_hsync, a_vsync, a_vidon, a_fs;
    logic [9:0] a_hc, a_vc;
    logic       b_hsync, b_vsync, b_vidon, b_fs;
    logic [9:0] b_hc, b_vc;

    int n_checks = 0;
    int n_errors = 0;
    int k = 0;            // clk edges since reset release
    int a_hs_low = 0, b_vid_cnt = 0, b_vs_low = 0, b_fs_cnt = 0, b_last_fs = -1;
    bit track = 1'b0;

    always #5 clk = ~clk;

    vga_640x480_timing u_dut_a (
        .clk(clk), .clr_n(clr_n), .hsync(a_hsync), .vsync(a_vsync),
        .hc(a_hc), .vc(a_vc), .vidon(a_vidon), .frame_start(a_fs)
    );

    vga_640x480_timing #(
        .HPIXELS(B_HP), .VLINES(B_VL), .HSP(B_HSP), .VSP(B_VSP),
        .HBP(B_HBP), .HFP(B_HFP), .VBP(B_VBP), .VFP(B_VFP)
    ) u_dut_b (
        .clk(clk), .clr_n(clr_n), .hsync(b_hsync), .vsync(b_vsync),
        .hc(b_hc), .vc(b_vc), .vidon(b_vidon), .frame_start(b_fs)
    );

    task automatic chk_val(input string tag, input int got, input int exp);
        n_checks++;
        if (got != exp) begin
            n_errors++;
            if (n_errors <= 40)
                $display("FAIL %s k=%0d got %0d expected %0d", tag, k, got, exp);
        end
    endtask

    // expected outputs from the number of pixel ticks since release
    task automatic model(input int hp, input int vl, input int hsp, input int hbp,
                         input int hfp, input int vsp, input int vbp, input int vfp,
                         output int hc, output int vc, output int hs, output int vs,
                         output int vid, output int fs);
        int t;
        t   = k / DIV;
        hc  = t % hp;
        vc  = (t / hp) % vl;
        hs  = (hc >= hsp) ? 1 : 0;
        vs  = (vc >= vsp) ? 1 : 0;
        vid = (hc >= hbp && hc < hfp && vc >= vbp && vc < vfp) ? 1 : 0;
        fs  = (t > 0 && (k % DIV) == 0 && (t % (hp * vl)) == 0) ? 1 : 0;
    endtask

    task automatic check_all();
        int hc, vc, hs, vs, vid, fs;
        model(800, 521, 128, 144, 784, 2, 31, 511, hc, vc, hs, vs, vid, fs);
        chk_val("a_hc", int'(a_hc), hc);
        chk_val("a_vc", int'(a_vc), vc);
        chk_val("a_hsync", int'(a_hsync), hs);
        chk_val("a_vsync", int'(a_vsync), vs);
        chk_val("a_vidon", int'(a_vidon), vid);
        chk_val("a_frame_start", int'(a_fs), fs);
        model(B_HP, B_VL, B_HSP, B_HBP, B_HFP, B_VSP, B_VBP, B_VFP, hc, vc, hs, vs, vid, fs);
        chk_val("b_hc", int'(b_hc), hc);
        chk_val("b_vc", int'(b_vc), vc);
        chk_val("b_hsync", int'(b_hsync), hs);
        chk_val("b_vsync", int'(b_vsync), vs);
        chk_val("b_vidon", int'(b_vidon), vid);
        chk_val("b_frame_start", int'(b_fs), fs);
    endtask

    // one clk: advance the model on the edge, check on the falling edge
    task automatic step();
        @(posedge clk);
        if (!clr_n) k = 0;
        else        k++;
        @(negedge clk);
        check_all();
        if (track) begin
            if (k >= 1 && k <= 800 * DIV && !a_hsync) a_hs_low++;
            if (k >= 1 && k <= B_HP * B_VL * DIV) begin
                if (b_vidon)  b_vid_cnt++;
                if (!b_vsync) b_vs_low++;
            end
            if (b_fs) begin
                b_fs_cnt++;
                if (b_last_fs >= 0) chk_val("b_fs_period", k - b_last_fs, B_HP * B_VL * DIV);
                b_last_fs = k;
            end
        end
    endtask

    initial begin
        clr_n = 1'b0;
        @(negedge clk);
        repeat (3) step();

        clr_n = 1'b1;
        track = 1'b1;
        // reaches vc=31 on the full-size instance, covering the first visible line
        repeat (26000 * DIV) step();
        track = 1'b0;
        chk_val("a_hsync_low_per_line", a_hs_low, 128 * DIV);
        chk_val("b_vidon_per_frame", b_vid_cnt, (B_HFP - B_HBP) * (B_VFP - B_VBP) * DIV);
        chk_val("b_vsync_low_per_frame", b_vs_low, B_VSP * B_HP * DIV);
        chk_val("b_fs_count", b_fs_cnt, (26000 * DIV) / (B_HP * B_VL * DIV));

        // random mid-frame resets of random length
        for (int i = 0; i < 20; i++) begin
            repeat ($urandom_range(1200, 20)) step();
            clr_n = 1'b0;
            repeat ($urandom_range(3, 1)) step();
            clr_n = 1'b1;
        end
        repeat (600 * DIV) step();

        $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
        $finish;
    end

endmodule
